// File: rtl/tuner_pkg.sv
// Shared defaults and state encodings for the FFT input frame buffer.
package tuner_pkg;

  localparam int FRAME_LEN_DEF = 1024;
  localparam int SAMPLE_W_DEF  = 16;
  localparam int FFTPTS_W      = $clog2(FRAME_LEN_DEF) + 1;

  typedef enum logic {
    WR_FILL,
    WR_HOLD
  } wrState_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_PRIME,
    RD_STREAM
  } rdState_t;

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port sample store holding both ping-pong banks; the bank is the address MSB.
module frame_ram #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read data only updates on an enabled read so a stalled prefetch keeps its value.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/fft_frame_buffer.sv
// Collects audio samples into ping-pong frames and streams each full frame to an
// Avalon-ST FFT sink, dropping input while both banks are occupied.
module fft_frame_buffer
  import tuner_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int SAMPLE_W  = SAMPLE_W_DEF
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic                          sample_valid,
  input  logic [31:0]                   sample_in,
  output logic                          sink_valid,
  input  logic                          sink_ready,
  output logic                          sink_sop,
  output logic                          sink_eop,
  output logic signed [SAMPLE_W-1:0]    sink_real,
  output logic [SAMPLE_W-1:0]           sink_imag,
  output logic [1:0]                    sink_error,
  output logic [$clog2(FRAME_LEN):0]    fftpts_in,
  output logic [15:0]                   drop_cnt
);

  localparam int AW = $clog2(FRAME_LEN);
  localparam int PW = AW + 1;
  localparam logic [AW-1:0] LAST = AW'(FRAME_LEN - 1);

  wrState_t            wrState_q, wrState_d;
  logic                wrBank_q, wrBank_d;
  logic [AW-1:0]       wrAddr_q, wrAddr_d;
  rdState_t            rdState_q, rdState_d;
  logic                rdBank_q, rdBank_d;
  logic [AW:0]         rdCnt_q, rdCnt_d;
  logic                aValid_q, aValid_d;
  logic [AW-1:0]       aAddr_q, aAddr_d;
  logic                outValid_q, outValid_d;
  logic                outSop_q, outSop_d;
  logic                outEop_q, outEop_d;
  logic [SAMPLE_W-1:0] outReal_q, outReal_d;
  logic [15:0]         drop_q, drop_d;

  logic                xfer, readerFree, frameDone, handoff;
  logic                bAdvance, aFree, ramWe, ramRe, unusedLow;
  logic [SAMPLE_W-1:0] ramRdata;

  assign unusedLow  = ^sample_in[31-SAMPLE_W:0];
  assign xfer       = outValid_q && sink_ready;
  // A reader finishing its eop beat this cycle can accept the next frame immediately.
  assign readerFree = (rdState_q == RD_IDLE) || (xfer && outEop_q);
  assign frameDone  = (wrState_q == WR_FILL) && sample_valid && (wrAddr_q == LAST);
  assign handoff    = (frameDone || (wrState_q == WR_HOLD)) && readerFree;
  assign bAdvance   = !outValid_q || xfer;
  assign aFree      = !aValid_q || bAdvance;
  assign ramWe      = sample_valid && (wrState_q == WR_FILL);
  assign ramRe      = (rdState_q != RD_IDLE) && (rdCnt_q != PW'(FRAME_LEN)) && aFree;

  frame_ram #(
    .DEPTH (2 * FRAME_LEN),
    .WIDTH (SAMPLE_W)
  ) u_ram (
    .clk_i   (CLOCK_50),
    .we_i    (ramWe),
    .waddr_i ({wrBank_q, wrAddr_q}),
    .wdata_i (sample_in[31 -: SAMPLE_W]),
    .re_i    (ramRe),
    .raddr_i ({rdBank_q, rdCnt_q[AW-1:0]}),
    .rdata_o (ramRdata)
  );

  always_comb begin
    wrState_d  = wrState_q;
    wrBank_d   = wrBank_q;
    wrAddr_d   = wrAddr_q;
    rdState_d  = rdState_q;
    rdBank_d   = rdBank_q;
    rdCnt_d    = rdCnt_q;
    aValid_d   = aValid_q;
    aAddr_d    = aAddr_q;
    outValid_d = outValid_q;
    outSop_d   = outSop_q;
    outEop_d   = outEop_q;
    outReal_d  = outReal_q;
    drop_d     = drop_q;

    if (ramWe) wrAddr_d = wrAddr_q + AW'(1);
    if (frameDone && !readerFree) wrState_d = WR_HOLD;
    if ((wrState_q == WR_HOLD) && sample_valid && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;

    // Two-stage read pipe: RAM output register feeds the output register.
    if (ramRe) begin
      rdCnt_d  = rdCnt_q + PW'(1);
      aAddr_d  = rdCnt_q[AW-1:0];
      aValid_d = 1'b1;
    end else if (bAdvance) begin
      aValid_d = 1'b0;
    end
    if (bAdvance) begin
      outValid_d = aValid_q;
      outSop_d   = aValid_q && (aAddr_q == '0);
      outEop_d   = aValid_q && (aAddr_q == LAST);
      if (aValid_q) outReal_d = ramRdata;
    end

    case (rdState_q)
      RD_PRIME:  if (aValid_q) rdState_d = RD_STREAM;
      RD_STREAM: if (xfer && outEop_q) rdState_d = RD_IDLE;
      default:   rdState_d = rdState_q;
    endcase

    if (handoff) begin
      wrState_d = WR_FILL;
      wrBank_d  = ~wrBank_q;
      wrAddr_d  = '0;
      rdState_d = RD_PRIME;
      rdBank_d  = wrBank_q;
      rdCnt_d   = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wrState_q  <= WR_FILL;
      wrBank_q   <= 1'b0;
      wrAddr_q   <= '0;
      rdState_q  <= RD_IDLE;
      rdBank_q   <= 1'b0;
      rdCnt_q    <= '0;
      aValid_q   <= 1'b0;
      aAddr_q    <= '0;
      outValid_q <= 1'b0;
      outSop_q   <= 1'b0;
      outEop_q   <= 1'b0;
      outReal_q  <= '0;
      drop_q     <= '0;
    end else begin
      wrState_q  <= wrState_d;
      wrBank_q   <= wrBank_d;
      wrAddr_q   <= wrAddr_d;
      rdState_q  <= rdState_d;
      rdBank_q   <= rdBank_d;
      rdCnt_q    <= rdCnt_d;
      aValid_q   <= aValid_d;
      aAddr_q    <= aAddr_d;
      outValid_q <= outValid_d;
      outSop_q   <= outSop_d;
      outEop_q   <= outEop_d;
      outReal_q  <= outReal_d;
      drop_q     <= drop_d;
    end
  end

  assign sink_valid = outValid_q;
  assign sink_sop   = outSop_q;
  assign sink_eop   = outEop_q;
  assign sink_real  = outReal_q;
  assign sink_imag  = '0;
  assign sink_error = '0;
  assign fftpts_in  = PW'(FRAME_LEN);
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench for fft_frame_buffer with 8-point frames: streaming, backpressure,
// overflow drops, truncation, mid-stream reset and back-to-back frame handoff.
module tb_fft_frame_buffer;

  localparam int FL = 8;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n;
  logic        sample_valid;
  logic [31:0] sample_in;
  logic        sink_valid;
  logic        sink_ready;
  logic        sink_sop;
  logic        sink_eop;
  logic [15:0] sink_real;
  logic [15:0] sink_imag;
  logic [1:0]  sink_error;
  logic [3:0]  fftpts_in;
  logic [15:0] drop_cnt;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          nBeats = 0;
  int          lastSampleCyc = 0;
  bit          toggleReady = 1'b0;
  logic [15:0] expData[$];
  int          beatCyc[$];
  logic [31:0] vec4[8];

  fft_frame_buffer #(.FRAME_LEN(FL), .SAMPLE_W(16)) dut (
    .CLOCK_50     (CLOCK_50),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_real    (sink_real),
    .sink_imag    (sink_imag),
    .sink_error   (sink_error),
    .fftpts_in    (fftpts_in),
    .drop_cnt     (drop_cnt)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock of stimulus; every valid output cycle is checked against the next expected beat.
  task automatic applyStimulus(input logic v, input logic [31:0] d);
    sample_valid = v;
    sample_in    = d;
    if (toggleReady) sink_ready = ~sink_ready;
    checkOutput("imag", sink_imag, 0);
    checkOutput("error", sink_error, 0);
    checkOutput("fftpts", fftpts_in, FL);
    if (sink_valid) begin
      if (nBeats < expData.size()) begin
        checkOutput("real", sink_real, expData[nBeats]);
        checkOutput("sop", sink_sop, (nBeats % FL) == 0);
        checkOutput("eop", sink_eop, (nBeats % FL) == FL - 1);
      end else begin
        checkOutput("beatOverrun", nBeats, expData.size());
      end
      if (sink_ready) begin
        beatCyc.push_back(cyc);
        nBeats++;
      end
    end
    if (v) lastSampleCyc = cyc;
    @(posedge CLOCK_50);
    #1;
    cyc++;
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0);
  endtask

  task automatic clearModel();
    nBeats = 0;
    expData.delete();
    beatCyc.delete();
  endtask

  task automatic feedCounting(input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      expData.push_back(16'(k));
      applyStimulus(1'b1, 32'(k) << 16);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    sample_valid = 1'b0;
    sample_in    = 32'h0;
    sink_ready   = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    checkOutput("rstValid", sink_valid, 0);
    checkOutput("rstSop", sink_sop, 0);
    checkOutput("rstEop", sink_eop, 0);
    checkOutput("rstReal", sink_real, 0);
    checkOutput("rstDrop", drop_cnt, 0);
    reset_n = 1'b1;
    runIdle(2);

    $display("[TB] basic frame, ready held high");
    clearModel();
    feedCounting(1, FL);
    runIdle(20);
    checkOutput("t1Beats", nBeats, FL);
    if (nBeats == FL) begin
      checkOutput("t1Contig", beatCyc[FL-1] - beatCyc[0], FL - 1);
      checkOutput("t1Latency", (beatCyc[0] - lastSampleCyc) <= 3, 1);
    end

    $display("[TB] same frame, ready toggling");
    clearModel();
    toggleReady = 1'b1;
    feedCounting(1, FL);
    runIdle(40);
    toggleReady = 1'b0;
    sink_ready  = 1'b1;
    checkOutput("t2Beats", nBeats, FL);
    runIdle(4);

    $display("[TB] ready low, 20 samples");
    clearModel();
    sink_ready = 1'b0;
    feedCounting(1, 2 * FL);
    for (int k = 17; k <= 20; k++) applyStimulus(1'b1, 32'(k) << 16);
    runIdle(4);
    checkOutput("t3Drop", drop_cnt, 4);
    checkOutput("t3Held", sink_valid, 1);
    sink_ready = 1'b1;
    runIdle(40);
    checkOutput("t3Beats", nBeats, 2 * FL);
    checkOutput("t3DropAfter", drop_cnt, 4);

    $display("[TB] truncation");
    clearModel();
    vec4 = '{32'hFFFF_8000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_ABCD,
             32'h0000_FFFF, 32'hFFFF_0000, 32'h0001_0000, 32'h5A5A_0000};
    expData = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234, 16'h0000, 16'hFFFF, 16'h0001, 16'h5A5A};
    for (int i = 0; i < FL; i++) applyStimulus(1'b1, vec4[i]);
    runIdle(20);
    checkOutput("t4Beats", nBeats, FL);

    $display("[TB] reset mid stream");
    clearModel();
    feedCounting(16'h41, FL);
    for (int i = 0; i < 30 && nBeats < 3; i++) applyStimulus(1'b0, 32'h0);
    checkOutput("t5MidBeats", nBeats, 3);
    reset_n = 1'b0;
    #1;
    checkOutput("t5Valid", sink_valid, 0);
    checkOutput("t5Drop", drop_cnt, 0);
    checkOutput("t5Sop", sink_sop, 0);
    @(posedge CLOCK_50);
    #1;
    cyc++;
    reset_n = 1'b1;
    clearModel();
    runIdle(2);
    feedCounting(16'h51, FL);
    runIdle(20);
    checkOutput("t5Beats", nBeats, FL);

    $display("[TB] frame completes on eop transfer");
    clearModel();
    feedCounting(16'h61, FL);
    for (int i = 0; i < 20 && !sink_valid; i++) applyStimulus(1'b0, 32'h0);
    checkOutput("t6Started", sink_valid, 1);
    feedCounting(16'h71, FL);
    runIdle(30);
    checkOutput("t6Beats", nBeats, 2 * FL);
    if (nBeats == 2 * FL) begin
      checkOutput("t6Back2Back", beatCyc[FL-1] - beatCyc[0], FL - 1);
      checkOutput("t6Latency", (beatCyc[FL] - lastSampleCyc) <= 3, 1);
    end
    checkOutput("t6Drop", drop_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_frame_buffer.md
FFT_FRAME_BUFFER -- requirements
Module: fft_frame_buffer

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 1024, FFT points per frame (power of 2, 8..2048).
REQ-002 SHALL have parameter SAMPLE_W, default 16, width of sink_real/sink_imag.
REQ-003 SHALL have port CLOCK_50  in  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port sample_valid  in  1  new audio sample present this cycle (audio controller available/read strobe).
REQ-006 SHALL have port sample_in  in  32  signed left-channel audio sample.
REQ-007 SHALL have port sink_valid  out  1  Avalon-ST valid to FFT.
REQ-008 SHALL have port sink_ready  in  1  Avalon-ST ready from FFT.
REQ-009 SHALL have port sink_sop  out  1  first sample of frame.
REQ-010 SHALL have port sink_eop  out  1  last sample of frame.
REQ-011 SHALL have port sink_real  out  SAMPLE_W  signed sample.
REQ-012 SHALL have port sink_imag  out  SAMPLE_W  constant 0.
REQ-013 SHALL have port sink_error  out  2  constant 0.
REQ-014 SHALL have port fftpts_in  out  log2(FRAME_LEN)+1  constant FRAME_LEN.
REQ-015 SHALL have port drop_cnt  out  16  saturating count of discarded samples.

Function
REQ-016 SHALL store sample_in[31:32-SAMPLE_W] (truncation, no rounding) on every cycle sample_valid=1, unless discarding.
REQ-017 SHALL use two FRAME_LEN-deep banks (ping-pong): writer fills one bank sequentially from address 0 while reader streams the other.
REQ-018 Writer states: FILL (writing), HOLD (bank full, reader busy); FILL->HOLD on write of address FRAME_LEN-1 when reader is not IDLE; FILL->FILL with bank swap and address 0 when reader is IDLE; HOLD->FILL with bank swap when reader returns to IDLE.
REQ-019 In HOLD, every sample_valid cycle SHALL be discarded and drop_cnt incremented, saturating at 16'hFFFF.
REQ-020 Reader states: IDLE, PRIME (RAM read latency), STREAM; IDLE->PRIME on bank handoff; PRIME->STREAM after read data valid; STREAM->IDLE on the cycle the eop beat transfers.
REQ-021 A beat SHALL transfer only when sink_valid=1 and sink_ready=1; sink_real, sop, eop SHALL be held stable while sink_valid=1 and sink_ready=0.
REQ-022 With sink_ready held 1, reader SHALL deliver FRAME_LEN back-to-back beats (prefetch register, no bubbles).
REQ-023 sink_sop SHALL be 1 only on beat 0, sink_eop only on beat FRAME_LEN-1; samples in arrival order.
REQ-024 First sink_valid of a frame SHALL assert no more than 3 cycles after the sample_valid cycle that completed that frame (reader idle).
REQ-025 Simultaneous frame completion and reader eop transfer SHALL count as reader IDLE: swap immediately, no sample dropped.
REQ-026 sink_valid SHALL never be 1 while reader is IDLE.

Reset
REQ-027 On reset_n=0, asynchronously: sink_valid, sink_sop, sink_eop, sink_real=0, drop_cnt=0, writer FILL at bank 0 address 0, reader IDLE.
REQ-028 Reset mid-frame SHALL discard partial write and in-flight read frames; no stale beat after release.
REQ-029 RAM contents need no reset.

Structure
REQ-030 Package tuner_pkg SHALL hold FRAME_LEN, SAMPLE_W defaults, FFTPTS_W, writer/reader state encodings.
REQ-031 SHALL instantiate one sub-module frame_ram: simple dual-port, 2*FRAME_LEN x SAMPLE_W, 1 write and 1 registered read port, bank = address MSB.
REQ-032 Target 120-400 lines RTL total.

Verification (bench FRAME_LEN=8)
REQ-033 Samples 32'h0001_0000..32'h0008_0000 on 8 consecutive cycles, sink_ready=1 -> 8 contiguous beats sink_real 1..8, sop on 1, eop on 8, first valid <=3 cycles after last input.
REQ-034 Same frame, sink_ready toggling 1/0 each cycle -> same 8 values, held stable during ready=0, 8 transfers only.
REQ-035 sink_ready=0, feed 20 samples -> first frame held, second frame fills, 4 samples dropped, drop_cnt=4.
REQ-036 Input 32'hFFFF_8000 -> sink_real=16'hFFFF; sink_imag=0, sink_error=0, fftpts_in=8 throughout.
REQ-037 reset_n pulsed low after beat 3 of streaming -> sink_valid=0 same cycle, drop_cnt=0, next 8 samples produce clean frame with sop on first.
REQ-038 Frame 2 completes on cycle frame 1 eop transfers -> frame 2 streams, drop_cnt unchanged.
